// File: rtl/rgb_to_gray.sv
// RGB565 byte stream (high byte first) to luma pixel stream.
// One output register with valid/ready; sustains one pixel every two byte cycles.
module rgb_to_gray #(
  parameter int unsigned RGB_SPLIT_W   = 8,
  parameter int unsigned GRAY_PXL_W    = 8,
  parameter int unsigned FRAME_PXL_NUM = 76800
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_sync_i,
  input  logic [RGB_SPLIT_W-1:0] rgb_byte_dat_i,
  input  logic                   rgb_byte_vld_i,
  output logic                   rgb_byte_rdy_o,
  output logic [GRAY_PXL_W-1:0]  gray_pxl_dat_o,
  output logic                   gray_pxl_vld_o,
  output logic                   gray_pxl_last_o,
  input  logic                   gray_pxl_rdy_i
);

  localparam int unsigned CNT_W = (FRAME_PXL_NUM > 1) ? $clog2(FRAME_PXL_NUM) : 1;
  localparam int unsigned SUM_W = 17;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PXL_NUM - 1);

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  phase_e                 phase_q, phase_d;
  logic [RGB_SPLIT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [GRAY_PXL_W-1:0]  dat_d;
  logic                   vld_d;
  logic                   last_d;

  logic                   in_hs_c;
  logic                   out_hs_c;
  rgb565_t                pxl_c;
  logic [7:0]             r8_c, g8_c, b8_c;
  logic [SUM_W-1:0]       y_sum_c;
  logic [GRAY_PXL_W-1:0]  gray_c;

  // Input may be taken whenever the output register can absorb a new pixel.
  assign rgb_byte_rdy_o = rst_n & ~frame_sync_i &
                          ((phase_q == PH_HI) | ~gray_pxl_vld_o | gray_pxl_rdy_i);
  assign in_hs_c  = rgb_byte_vld_i & rgb_byte_rdy_o;
  assign out_hs_c = gray_pxl_vld_o & gray_pxl_rdy_i;

  // Pixel assembly, 5/6-bit to 8-bit replication, and rounded luma weighting.
  assign pxl_c   = rgb565_t'(16'({hi_q, rgb_byte_dat_i}));
  assign r8_c    = {pxl_c.r, pxl_c.r[4:2]};
  assign g8_c    = {pxl_c.g, pxl_c.g[5:4]};
  assign b8_c    = {pxl_c.b, pxl_c.b[4:2]};
  assign y_sum_c = SUM_W'(77)  * SUM_W'(r8_c)
                 + SUM_W'(150) * SUM_W'(g8_c)
                 + SUM_W'(29)  * SUM_W'(b8_c)
                 + SUM_W'(128);
  assign gray_c  = GRAY_PXL_W'(y_sum_c >> 8);

  // Next-state: byte phase, high-byte capture, pixel counter, output register.
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    dat_d   = gray_pxl_dat_o;
    vld_d   = gray_pxl_vld_o;
    last_d  = gray_pxl_last_o;

    if (out_hs_c) begin
      vld_d = 1'b0;
    end

    if (frame_sync_i) begin
      phase_d = PH_HI;
      cnt_d   = '0;
    end else if (in_hs_c) begin
      case (phase_q)
        PH_HI: begin
          hi_d    = rgb_byte_dat_i;
          phase_d = PH_LO;
        end
        PH_LO: begin
          phase_d = PH_HI;
          dat_d   = gray_c;
          vld_d   = 1'b1;
          last_d  = (cnt_q == CNT_LAST);
          cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q         <= PH_HI;
      hi_q            <= '0;
      cnt_q           <= '0;
      gray_pxl_dat_o  <= '0;
      gray_pxl_vld_o  <= 1'b0;
      gray_pxl_last_o <= 1'b0;
    end else begin
      phase_q         <= phase_d;
      hi_q            <= hi_d;
      cnt_q           <= cnt_d;
      gray_pxl_dat_o  <= dat_d;
      gray_pxl_vld_o  <= vld_d;
      gray_pxl_last_o <= last_d;
    end
  end

endmodule
